// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one sequential multiplier between two
// requesters: latches operands, pulses start, waits for finish or timeout, returns the result.
module mult_share_arbiter #(
    parameter int WIDTH          = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic [WIDTH-1:0] mult_in1,
    output logic [WIDTH-1:0] mult_in2,
    output logic             mult_start,
    input  logic [WIDTH-1:0] mult_out,
    input  logic             mult_finish
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic             done0_q, done0_d, done1_q, done1_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] in1_q, in1_d, in2_q, in2_d;
    logic             start_q, start_d;

    logic any_req;
    logic win1;
    logic timeout_hit;

    // Port 1 wins when it is alone, or on a tie when port 0 was served last.
    assign any_req     = req0 | req1;
    assign win1        = req1 & (~req0 | ~last_q);
    assign timeout_hit = (cnt_q == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
            in1_q    <= '0;
            in2_q    <= '0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            result_q <= result_d;
            err_q    <= err_d;
            in1_q    <= in1_d;
            in2_q    <= in2_d;
            start_q  <= start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (any_req) state_d = ISSUE;
            ISSUE: state_d = WAIT;
            WAIT:  if (mult_finish || timeout_hit) state_d = RESP;
            RESP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        last_d   = last_q;
        gnt0_d   = gnt0_q;
        gnt1_d   = gnt1_q;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        result_d = result_q;
        err_d    = err_q;
        in1_d    = in1_q;
        in2_d    = in2_q;
        start_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    in1_d   = win1 ? a1 : a0;
                    in2_d   = win1 ? b1 : b0;
                    gnt0_d  = ~win1;
                    gnt1_d  = win1;
                    cnt_d   = '0;
                    start_d = 1'b1;
                end
            end
            ISSUE: ;
            WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // Finish beats timeout when both land in the same cycle.
                if (mult_finish) begin
                    result_d = mult_out;
                    err_d    = 1'b0;
                    done0_d  = gnt0_q;
                    done1_d  = gnt1_q;
                end else if (timeout_hit) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    done0_d  = gnt0_q;
                    done1_d  = gnt1_q;
                end
            end
            RESP: begin
                last_d = gnt1_q;
                gnt0_d = 1'b0;
                gnt1_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign gnt0       = gnt0_q;
    assign gnt1       = gnt1_q;
    assign done0      = done0_q;
    assign done1      = done1_q;
    assign result     = result_q;
    assign err        = err_q;
    assign mult_in1   = in1_q;
    assign mult_in2   = in2_q;
    assign mult_start = start_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: multiplier stub with per-requester latency
// (0 = never finishes) and a latency/arbitration reference model.
module tb_mult_share_arbiter;

    localparam int W = 16;
    localparam int T = 8;

    logic         clk = 1'b0;
    logic         nRST;
    logic         req0, req1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         gnt0, gnt1, done0, done1, err, mult_start, mult_finish;
    logic [W-1:0] result, mult_in1, mult_in2, mult_out;

    int checks   = 0;
    int failures = 0;
    int m_last   = 1;

    mult_share_arbiter #(.WIDTH(W), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .nRST(nRST),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result), .err(err),
        .mult_in1(mult_in1), .mult_in2(mult_in2), .mult_start(mult_start),
        .mult_out(mult_out), .mult_finish(mult_finish)
    );

    always #5 clk = ~clk;

    // Multiplier stub
    int           lat0 = 1, lat1 = 1;
    logic         s_busy, s_hang, spur;
    int           s_cnt;
    logic [W-1:0] s_prod, junk;
    logic         s_fin;

    always @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            s_busy <= 1'b0;
            s_hang <= 1'b0;
            s_cnt  <= 0;
            s_prod <= '0;
        end else if (mult_start) begin
            s_busy <= 1'b1;
            s_hang <= ((gnt0 ? lat0 : lat1) == 0);
            s_cnt  <= (gnt0 ? lat0 : lat1) - 1;
            s_prod <= W'(mult_in1 * mult_in2);
        end else if (s_busy && !s_hang) begin
            if (s_cnt == 0) s_busy <= 1'b0;
            else            s_cnt  <= s_cnt - 1;
        end
    end

    assign s_fin       = s_busy && !s_hang && (s_cnt == 0);
    assign mult_finish = s_fin || spur;
    assign mult_out    = s_fin ? s_prod : junk;

    // Invariant monitors, examined by test_invariants
    int   gnt_overlap = 0, done_overlap = 0, start_long = 0, done_long = 0;
    logic prev_start = 1'b0, prev_done = 1'b0;
    always @(negedge clk) begin
        if (gnt0 && gnt1)   gnt_overlap++;
        if (done0 && done1) done_overlap++;
        if (mult_start && prev_start) start_long++;
        if ((done0 || done1) && prev_done) done_long++;
        prev_start = mult_start;
        prev_done  = done0 || done1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    // Reference helpers: spec-level arithmetic only
    function automatic logic [W-1:0] mulw(input logic [W-1:0] x, input logic [W-1:0] y);
        longint p;
        logic [63:0] pv;
        p  = longint'(x) * longint'(y);
        pv = 64'(p);
        return pv[W-1:0];
    endfunction

    function automatic int eff_lat(input int l);
        return (l == 0 || l > T) ? T : l;
    endfunction

    function automatic logic times_out(input int l);
        return (l == 0 || l > T);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget, output int cyc, output int who, output bit got);
        cyc = 0; who = -1; got = 1'b0;
        while (cyc < budget && !got) begin
            tick();
            cyc++;
            if (done0)      begin got = 1'b1; who = 0; end
            else if (done1) begin got = 1'b1; who = 1; end
        end
    endtask

    task automatic wait_start(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            if (mult_start) got = 1'b1;
        end
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        tick();
        tick();
        nRST = 1'b1;
        m_last = 1;
        tick();
    endtask

    task automatic test_reset();
        logic [53:0] ov;
        nRST = 1'b0; req0 = 1'b0; req1 = 1'b0; spur = 1'b0; junk = 16'hBEEF;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        #3;
        ov = {gnt0, gnt1, done0, done1, err, mult_start, result, mult_in1, mult_in2};
        checks++;
        if (ov !== '0) begin failures++; $display("FAIL reset_outputs got %h required 0", ov); end
        tick();
        nRST = 1'b1;
        tick();
        tick();
        ov = {gnt0, gnt1, done0, done1, err, mult_start, result, mult_in1, mult_in2};
        checks++;
        if (ov !== '0) begin failures++; $display("FAIL idle_after_reset got %h required 0", ov); end
    endtask

    task automatic test_single();
        int cyc, who; bit got;
        lat0 = 4; a0 = 16'd12; b0 = 16'd10; req0 = 1'b1;
        tick();
        checks++;
        if ({gnt0, gnt1, mult_start} !== 3'b101) begin
            failures++; $display("FAIL single_issue got gnt0/gnt1/start=%b required 101", {gnt0, gnt1, mult_start});
        end
        checks++;
        if (mult_in1 !== 16'd12 || mult_in2 !== 16'd10) begin
            failures++; $display("FAIL single_operands got %0d,%0d required 12,10", mult_in1, mult_in2);
        end
        wait_done(20, cyc, who, got);
        req0 = 1'b0;
        checks++;
        if (!got || who != 0 || cyc + 1 != 6) begin
            failures++; $display("FAIL single_latency got who=%0d cycles=%0d required who=0 cycles=6", who, cyc + 1);
        end
        checks++;
        if (result !== 16'd120 || err !== 1'b0) begin
            failures++; $display("FAIL single_result got %0d err=%b required 120 err=0", result, err);
        end
        m_last = 0;
        tick();
        checks++;
        if ({done0, done1, gnt0, gnt1} !== 4'b0000) begin
            failures++; $display("FAIL single_release got done/gnt=%b required 0000", {done0, done1, gnt0, gnt1});
        end
    endtask

    task automatic test_tie();
        int cyc, who; bit got;
        do_reset();
        lat0 = 2; lat1 = 2;
        a0 = 16'd3; b0 = 16'd10; a1 = 16'd7; b1 = 16'd6;
        req0 = 1'b1; req1 = 1'b1;
        wait_done(20, cyc, who, got);
        req0 = 1'b0;
        checks++;
        if (!got || who != 0 || result !== 16'd30 || err !== 1'b0) begin
            failures++; $display("FAIL tie_first got who=%0d result=%0d err=%b required who=0 result=30 err=0", who, result, err);
        end
        wait_done(20, cyc, who, got);
        req1 = 1'b0;
        checks++;
        if (!got || who != 1 || result !== 16'd42 || err !== 1'b0) begin
            failures++; $display("FAIL tie_second got who=%0d result=%0d err=%b required who=1 result=42 err=0", who, result, err);
        end
        m_last = 1;
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc, who, exp_who, l; bit got;
        logic [W-1:0] exp_r;
        a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
        lat0 = $urandom_range(1, 5); lat1 = $urandom_range(1, 5);
        req0 = 1'b1; req1 = 1'b1;
        for (int t = 0; t < 4; t++) begin
            exp_who = (m_last == 1) ? 0 : 1;
            l = (exp_who == 0) ? lat0 : lat1;
            wait_start(4, got);
            checks++;
            if (!got || {gnt1, gnt0} !== ((exp_who == 0) ? 2'b01 : 2'b10)) begin
                failures++; $display("FAIL b2b_grant[%0d] got gnt1/gnt0=%b required port %0d", t, {gnt1, gnt0}, exp_who);
            end
            wait_done(1 + eff_lat(l) + 2, cyc, who, got);
            exp_r = (exp_who == 0) ? mulw(a0, b0) : mulw(a1, b1);
            checks++;
            if (!got || who != exp_who || cyc != 1 + eff_lat(l) || result !== exp_r || err !== 1'b0) begin
                failures++;
                $display("FAIL b2b_done[%0d] got who=%0d cyc=%0d result=%h required who=%0d cyc=%0d result=%h",
                         t, who, cyc, result, exp_who, 1 + eff_lat(l), exp_r);
            end
            m_last = exp_who;
            if (exp_who == 0) lat0 = $urandom_range(1, 5); else lat1 = $urandom_range(1, 5);
            if (t == 3) begin
                req0 = 1'b0; req1 = 1'b0;
            end
            tick();
            checks++;
            if ({gnt0, gnt1, mult_start} !== 3'b000) begin
                failures++; $display("FAIL b2b_idle_gap[%0d] got gnt0/gnt1/start=%b required 000", t, {gnt0, gnt1, mult_start});
            end
        end
    endtask

    task automatic test_timeout();
        int cyc, who; bit got;
        int lats[3] = '{0, T, T + 1};
        for (int k = 0; k < 3; k++) begin
            lat0 = lats[k]; a0 = 16'd250; b0 = 16'd300; req0 = 1'b1;
            tick();
            wait_done(T + 6, cyc, who, got);
            req0 = 1'b0;
            checks++;
            if (!got || who != 0 || cyc + 1 != 2 + T) begin
                failures++; $display("FAIL timeout_latency[%0d] got who=%0d cycles=%0d required who=0 cycles=%0d", k, who, cyc + 1, 2 + T);
            end
            checks++;
            if (err !== times_out(lats[k]) || result !== (times_out(lats[k]) ? 16'd0 : mulw(16'd250, 16'd300))) begin
                failures++; $display("FAIL timeout_result[%0d] got result=%h err=%b required err=%b", k, result, err, times_out(lats[k]));
            end
            m_last = 0;
            tick();
            tick();
        end
        lat1 = 3; a1 = 16'd9; b1 = 16'd11; req1 = 1'b1;
        wait_done(12, cyc, who, got);
        req1 = 1'b0;
        checks++;
        if (!got || who != 1 || result !== 16'd99 || err !== 1'b0) begin
            failures++; $display("FAIL after_timeout got who=%0d result=%0d err=%b required who=1 result=99 err=0", who, result, err);
        end
        m_last = 1;
        tick();
    endtask

    task automatic test_reset_mid();
        int cyc, who; bit got;
        logic [53:0] ov;
        lat0 = 0; a0 = 16'd5; b0 = 16'd5; req0 = 1'b1;
        tick(); tick(); tick();
        nRST = 1'b0;
        #1;
        ov = {gnt0, gnt1, done0, done1, err, mult_start, result, mult_in1, mult_in2};
        checks++;
        if (ov !== '0) begin failures++; $display("FAIL reset_mid_outputs got %h required 0", ov); end
        req0 = 1'b0;
        tick();
        nRST = 1'b1;
        m_last = 1;
        tick();
        lat1 = 2; a1 = 16'd1234; b1 = 16'd3; req1 = 1'b1;
        wait_done(12, cyc, who, got);
        req1 = 1'b0;
        checks++;
        if (!got || who != 1 || cyc != 4 || result !== 16'd3702 || err !== 1'b0) begin
            failures++; $display("FAIL reset_mid_recover got who=%0d cyc=%0d result=%0d required who=1 cyc=4 result=3702", who, cyc, result);
        end
        m_last = 1;
        tick();
    endtask

    task automatic test_spurious();
        int cyc, who; bit got;
        junk = 16'hDEAD;
        spur = 1'b1;
        tick();
        spur = 1'b0;
        tick();
        checks++;
        if ({done0, done1, gnt0, gnt1, err} !== 5'b00000) begin
            failures++; $display("FAIL spurious_idle got done/gnt/err=%b required 00000", {done0, done1, gnt0, gnt1, err});
        end
        lat0 = 3; a0 = 16'd21; b0 = 16'd2; req0 = 1'b1;
        tick();
        spur = 1'b1;
        tick();
        spur = 1'b0;
        wait_done(12, cyc, who, got);
        req0 = 1'b0;
        checks++;
        if (!got || who != 0 || cyc + 2 != 5 || result !== 16'd42 || err !== 1'b0) begin
            failures++; $display("FAIL spurious_txn got who=%0d cycles=%0d result=%h required who=0 cycles=5 result=002a", who, cyc + 2, result);
        end
        m_last = 0;
        tick();
    endtask

    task automatic test_random();
        int cyc, who, mode, exp_who, l; bit got;
        bit pend[2];
        logic [W-1:0] exp_r;
        for (int it = 0; it < 40; it++) begin
            mode = $urandom_range(0, 2);
            a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
            lat0 = $urandom_range(0, 10); lat1 = $urandom_range(0, 10);
            pend[0] = (mode != 1);
            pend[1] = (mode != 0);
            req0 = pend[0]; req1 = pend[1];
            while (pend[0] || pend[1]) begin
                if (pend[0] && pend[1]) exp_who = (m_last == 1) ? 0 : 1;
                else                    exp_who = pend[0] ? 0 : 1;
                l = (exp_who == 0) ? lat0 : lat1;
                wait_start(4, got);
                checks++;
                if (!got || {gnt1, gnt0} !== ((exp_who == 0) ? 2'b01 : 2'b10)) begin
                    failures++; $display("FAIL rand_grant[%0d] got gnt1/gnt0=%b required port %0d", it, {gnt1, gnt0}, exp_who);
                end
                wait_done(1 + eff_lat(l) + 3, cyc, who, got);
                exp_r = times_out(l) ? '0 : ((exp_who == 0) ? mulw(a0, b0) : mulw(a1, b1));
                checks++;
                if (!got || who != exp_who || cyc != 1 + eff_lat(l) || result !== exp_r || err !== times_out(l)) begin
                    failures++;
                    $display("FAIL rand_done[%0d] got who=%0d cyc=%0d result=%h err=%b required who=%0d cyc=%0d result=%h err=%b",
                             it, who, cyc, result, err, exp_who, 1 + eff_lat(l), exp_r, times_out(l));
                end
                pend[exp_who] = 1'b0;
                if (exp_who == 0) req0 = 1'b0; else req1 = 1'b0;
                m_last = exp_who;
                if (!got) begin
                    pend[0] = 1'b0; pend[1] = 1'b0; req0 = 1'b0; req1 = 1'b0;
                end
            end
            tick();
            tick();
        end
    endtask

    task automatic test_invariants();
        checks++;
        if (gnt_overlap != 0 || done_overlap != 0) begin
            failures++; $display("FAIL exclusivity got gnt_overlap=%0d done_overlap=%0d required 0,0", gnt_overlap, done_overlap);
        end
        checks++;
        if (start_long != 0 || done_long != 0) begin
            failures++; $display("FAIL pulse_width got start_long=%0d done_long=%0d required 0,0", start_long, done_long);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_spurious();
        test_random();
        test_invariants();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
